spi_peripheral_rx: RTL and testbench

- SPI mode-0 peripheral receiver; the receiving end of the display-side SPI controller interface (sclk, csb, mosi, dcx).
- Oversamples the serial lines on the system clock and assembles N-bit words, MSB first.
- Presents each word with its D/CX flag on a valid/ready output.
- Used as the bus-functional endpoint in etch-a-sketch display benches and as the receive path for board-to-board links.

---
 rtl/spi_rx_pkg.sv | 11 +
 rtl/comparator_eq.sv | 12 +
 rtl/synchronizer.sv | 24 ++
 rtl/spi_peripheral_rx.sv | 178 +++++++++++++++++
 tb/tb_spi_peripheral_rx.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_rx_pkg.sv
// Shared types and defaults for the SPI mode-0 peripheral receiver.
package spi_rx_pkg;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } spi_rx_state_t;

    localparam int SPI_RX_DEFAULT_SYNC = 2;

endpackage

// File: rtl/comparator_eq.sv
// Combinational equality comparator.
module comparator_eq #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         eq_o
);

    assign eq_o = (a_i == b_i);

endmodule

// File: rtl/synchronizer.sv
// Single-bit multi-flop synchronizer with a selectable reset level.
module synchronizer #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff_q <= {STAGES{RST_VAL}};
        end else begin
            ff_q <= {ff_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/spi_peripheral_rx.sv
// SPI mode-0 peripheral receiver: oversampled, MSB-first, valid/ready output.
// Optional o_word_count output is enabled with the SPI_RX_WORD_COUNT_EN macro.
module spi_peripheral_rx
    import spi_rx_pkg::*;
#(
    parameter int N           = 8,
    parameter int SYNC_STAGES = SPI_RX_DEFAULT_SYNC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sclk,
    input  logic         csb,
    input  logic         mosi,
    input  logic         dcx,
    output logic [N-1:0] o_data,
    output logic         o_dcx,
    output logic         o_valid,
    input  logic         i_ready,
    output logic         o_overrun,
    output logic         o_frame_err
`ifdef SPI_RX_WORD_COUNT_EN
    ,
    output logic [15:0]  o_word_count
`endif
);

    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic sync_sclk, sync_csb, sync_mosi, sync_dcx;

    synchronizer #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_i(sclk), .q_o(sync_sclk)
    );
    // Chip select idles high, so its chain resets to the deasserted level.
    synchronizer #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csb (
        .clk(clk), .rst(rst), .d_i(csb), .q_o(sync_csb)
    );
    synchronizer #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d_i(mosi), .q_o(sync_mosi)
    );
    synchronizer #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dcx (
        .clk(clk), .rst(rst), .d_i(dcx), .q_o(sync_dcx)
    );

    spi_rx_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-2:0]  shift_q, shift_d;
    logic          prev_sclk_q;
    logic [N-1:0]  data_q, data_d;
    logic          dcx_q, dcx_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;
    logic          ferr_q, ferr_d;
`ifdef SPI_RX_WORD_COUNT_EN
    logic [15:0]   wc_q, wc_d;
`endif

    logic          sclk_rise;
    logic          is_last;
    logic          complete;
    logic          xfer;
    logic [N-1:0]  word_in;

    assign sclk_rise = sync_sclk & ~prev_sclk_q;
    assign word_in   = {shift_q, sync_mosi};
    assign xfer      = valid_q & i_ready;

    comparator_eq #(.W(CW)) u_term_cnt (
        .a_i (cnt_q),
        .b_i (LAST),
        .eq_o(is_last)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        ferr_d   = 1'b0;
        complete = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!sync_csb) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end
            end
            S_SHIFT: begin
                if (sync_csb) begin
                    // Deselect mid-word drops the partial word.
                    state_d = S_IDLE;
                    ferr_d  = (cnt_q != '0);
                    cnt_d   = '0;
                end else if (sclk_rise) begin
                    shift_d = word_in[N-2:0];
                    if (is_last) begin
                        cnt_d    = '0;
                        complete = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        data_d  = data_q;
        dcx_d   = dcx_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (complete) begin
            if (!valid_q || i_ready) begin
                data_d  = word_in;
                dcx_d   = sync_dcx;
                valid_d = 1'b1;
            end else begin
                // Held word wins; the new word is lost and flagged.
                ovr_d = 1'b1;
            end
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

`ifdef SPI_RX_WORD_COUNT_EN
    always_comb begin
        wc_d = wc_q;
        if (xfer) begin
            wc_d = wc_q + 16'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            prev_sclk_q <= 1'b0;
            data_q      <= '0;
            dcx_q       <= 1'b0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
            ferr_q      <= 1'b0;
`ifdef SPI_RX_WORD_COUNT_EN
            wc_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            prev_sclk_q <= sync_sclk;
            data_q      <= data_d;
            dcx_q       <= dcx_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
            ferr_q      <= ferr_d;
`ifdef SPI_RX_WORD_COUNT_EN
            wc_q        <= wc_d;
`endif
        end
    end

    assign o_data      = data_q;
    assign o_dcx       = dcx_q;
    assign o_valid     = valid_q;
    assign o_overrun   = ovr_q;
    assign o_frame_err = ferr_q;
`ifdef SPI_RX_WORD_COUNT_EN
    assign o_word_count = wc_q;
`endif

endmodule

// File: tb/tb_spi_peripheral_rx.sv
// Directed and randomized bench for spi_peripheral_rx against a word-level reference model.
module tb_spi_peripheral_rx;

    localparam int N  = 8;
    localparam int SS = 2;

    logic         clk     = 1'b0;
    logic         rst     = 1'b1;
    logic         sclk    = 1'b0;
    logic         csb     = 1'b1;
    logic         mosi    = 1'b0;
    logic         dcx     = 1'b0;
    logic         i_ready = 1'b1;
    logic [N-1:0] o_data;
    logic         o_dcx;
    logic         o_valid;
    logic         o_overrun;
    logic         o_frame_err;
`ifdef SPI_RX_WORD_COUNT_EN
    logic [15:0]  o_word_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int ferr_cnt = 0;
    logic [N:0] got[$];
    logic [N:0] exp_q[$];

    always #5 clk = ~clk;

    spi_peripheral_rx #(.N(N), .SYNC_STAGES(SS)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .csb        (csb),
        .mosi       (mosi),
        .dcx        (dcx),
        .o_data     (o_data),
        .o_dcx      (o_dcx),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_overrun  (o_overrun),
        .o_frame_err(o_frame_err)
`ifdef SPI_RX_WORD_COUNT_EN
        ,
        .o_word_count(o_word_count)
`endif
    );

    // Transfer and frame-error observer, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst === 1'b0 && o_valid === 1'b1 && i_ready === 1'b1)
            got.push_back({o_dcx, o_data});
        if (o_frame_err === 1'b1)
            ferr_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic d);
        mosi = b;
        dcx  = d;
        sclk = 1'b0;
        tick(4);
        sclk = 1'b1;
        tick(4);
    endtask

    task automatic send_word(input logic [N-1:0] w, input logic [N-1:0] dv);
        for (int i = N - 1; i >= 0; i--) send_bit(w[i], dv[i]);
    endtask

    task automatic frame_start();
        sclk = 1'b0;
        csb  = 1'b0;
        tick(4);
    endtask

    task automatic frame_end();
        sclk = 1'b0;
        tick(2);
        csb = 1'b1;
        tick(6);
    endtask

    initial begin
        int base;
        int f0;
        int exp_ferr;
        int exp_wc;
        logic [N-1:0] w;
        logic [N-1:0] dv;
        logic [7:0] a5;

        // Reset held for three cycles with sclk toggling
        repeat (3) begin
            sclk = ~sclk;
            tick(1);
        end
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_dcx", o_dcx, 0);
        chk("rst_overrun", o_overrun, 0);
        chk("rst_frame_err", o_frame_err, 0);
        sclk = 1'b0;
        rst  = 1'b0;
        tick(4);
        chk("post_rst_valid", o_valid, 0);
`ifdef SPI_RX_WORD_COUNT_EN
        chk("rst_word_count", o_word_count, 0);
`endif
        exp_wc = 0;

        // Single word 0xA5 with latency measurement on the last bit
        base = got.size();
        a5 = 8'hA5;
        frame_start();
        for (int i = N - 1; i >= 1; i--) send_bit(a5[i], 1'b1);
        mosi = a5[0];
        dcx  = 1'b1;
        sclk = 1'b0;
        tick(4);
        sclk = 1'b1;
        for (int k = 1; k <= SS; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("lat_early", o_valid, 0);
        end
        @(posedge clk);
        @(negedge clk);
        chk("lat_valid", o_valid, 1);
        chk("lat_data", o_data, 8'hA5);
        chk("lat_dcx", o_dcx, 1);
        @(posedge clk);
        @(negedge clk);
        chk("single_pulse", o_valid, 0);
        tick(3);
        frame_end();
        chk("single_count", got.size() - base, 1);
        chk("single_word", got[base], {1'b1, 8'hA5});
        exp_wc += 1;

        // Back-to-back words in one frame
        base = got.size();
        f0 = ferr_cnt;
        frame_start();
        send_word(8'h2A, '0);
        send_word(8'h00, '1);
        frame_end();
        chk("b2b_count", got.size() - base, 2);
        chk("b2b_word0", got[base], {1'b0, 8'h2A});
        chk("b2b_word1", got[base+1], {1'b1, 8'h00});
        chk("b2b_no_ferr", ferr_cnt - f0, 0);
        exp_wc += 2;

        // Backpressure: second word dropped, overrun sticky
        base = got.size();
        i_ready = 1'b0;
        frame_start();
        send_word(8'h11, '1);
        send_word(8'h22, '0);
        frame_end();
        chk("bp_valid", o_valid, 1);
        chk("bp_data_held", o_data, 8'h11);
        chk("bp_overrun", o_overrun, 1);
        chk("bp_no_xfer", got.size() - base, 0);
        i_ready = 1'b1;
        tick(4);
        chk("bp_one_xfer", got.size() - base, 1);
        chk("bp_word", got[base], {1'b1, 8'h11});
        chk("bp_valid_low", o_valid, 0);
        chk("bp_overrun_sticky", o_overrun, 1);
        exp_wc += 1;

        // Frame error after 5 bits, then a clean 0xFF
        base = got.size();
        f0 = ferr_cnt;
        frame_start();
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
        frame_end();
        chk("ferr_pulse_cycles", ferr_cnt - f0, 1);
        chk("ferr_no_word", got.size() - base, 0);
        frame_start();
        send_word(8'hFF, '1);
        frame_end();
        chk("ferr_next_count", got.size() - base, 1);
        chk("ferr_next_word", got[base], {1'b1, 8'hFF});
        exp_wc += 1;

        // Randomized frames against the word-level model
        base = got.size();
        f0 = ferr_cnt;
        exp_ferr = 0;
        exp_q.delete();
        for (int f = 0; f < 6; f++) begin
            int nw;
            frame_start();
            nw = $urandom_range(1, 3);
            for (int j = 0; j < nw; j++) begin
                w  = N'($urandom);
                dv = N'($urandom);
                send_word(w, dv);
                exp_q.push_back({dv[0], w});
            end
            if ($urandom_range(0, 1) == 1) begin
                int k;
                k = $urandom_range(1, N - 1);
                for (int j = 0; j < k; j++) send_bit(1'($urandom), 1'($urandom));
                exp_ferr++;
            end
            frame_end();
        end
        chk("rand_count", got.size() - base, exp_q.size());
        for (int j = 0; j < exp_q.size(); j++) begin
            if (base + j < got.size())
                chk($sformatf("rand_word%0d", j), got[base+j], exp_q[j]);
            else
                chk($sformatf("rand_word%0d_missing", j), 0, exp_q[j]);
        end
        chk("rand_ferr", ferr_cnt - f0, exp_ferr);
        exp_wc += exp_q.size();
`ifdef SPI_RX_WORD_COUNT_EN
        chk("word_count", o_word_count, exp_wc);
`endif

        // Reset mid-word, then 0x3C in the same frame
        base = got.size();
        f0 = ferr_cnt;
        frame_start();
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        sclk = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_data", o_data, 0);
        chk("midrst_overrun", o_overrun, 0);
        tick(3);
        send_word(8'h3C, '1);
        frame_end();
        chk("midrst_count", got.size() - base, 1);
        chk("midrst_word", got[base], {1'b1, 8'h3C});
        chk("midrst_no_ferr", ferr_cnt - f0, 0);
`ifdef SPI_RX_WORD_COUNT_EN
        chk("midrst_word_count", o_word_count, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
